// File: rtl/i2c_pkg.sv
// Shared types and constants for the passive I2C bus monitor.
package i2c_pkg;

  localparam int unsigned I2C_BYTE_BITS = 8;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_DATA,
    MON_ACK
  } mon_state_e;

  // One received byte as presented to the consumer.
  typedef struct packed {
    logic [I2C_BYTE_BITS-1:0] data;
    logic                     ack;
    logic                     first;
  } i2c_byte_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Input conditioning for one I2C line: multi-flop synchroniser, optionally followed by a
// counter-based glitch filter (enabled with `I2C_GLITCH_FILTER_EN).
// All flops reset to 1 so an unconnected/idle bus reads as released.
module i2c_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic line_o
);

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_param_check
    $error("i2c_line_filter: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;

  // Shift the raw pin value through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Toggle only once FILT_LEN consecutive samples disagree with the current output.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_out != filt_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        filt_d = sync_out;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign line_o = filt_q;
`else
  assign line_o = sync_out;
`endif

endmodule

// File: rtl/i2c_bus_monitor.sv
// Passive I2C receive stage: detects START / repeated START / STOP, deserialises bytes plus
// the ACK bit and offers them on a valid/ready port through a one-deep holding register.
// Optional input glitch filtering is selected with `I2C_GLITCH_FILTER_EN.
module i2c_bus_monitor
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic [7:0] byte_data,
  output logic       byte_ack,
  output logic       byte_first,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       start_pulse,
  output logic       rstart_pulse,
  output logic       stop_pulse,
  output logic       bus_busy,
  output logic       overflow,
  output logic       frame_err
);

  localparam logic [3:0] LAST_BIT = 4'(I2C_BYTE_BITS - 1);

  logic scl_s, sda_s, scl_p, sda_p;
  logic start_cond, stop_cond, scl_rise;

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .line_i (scl_i),
    .line_o (scl_s)
  );

  i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filter (
    .clk    (clk),
    .reset_n(reset_n),
    .line_i (sda_i),
    .line_o (sda_s)
  );

  // SDA edges only count as conditions while SCL is stable high on both samples.
  assign start_cond = scl_p & scl_s & sda_p & ~sda_s;
  assign stop_cond  = scl_p & scl_s & ~sda_p & sda_s;
  assign scl_rise   = ~scl_p & scl_s;

  mon_state_e                 state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [I2C_BYTE_BITS-1:0]   shift_q, shift_d;
  logic                       first_q, first_d;
  logic                       busy_q, busy_d;
  logic                       start_q, start_d, rstart_q, rstart_d;
  logic                       stop_q, stop_d, ferr_q, ferr_d;
  i2c_byte_t                  comp_q, comp_d;
  logic                       comp_valid_q, comp_valid_d;
  i2c_byte_t                  hold_q, hold_d;
  logic                       hold_valid_q, hold_valid_d;
  logic                       ovf_q, ovf_d;
  logic                       mid_byte;

  // A condition arriving with part of a byte shifted is a framing error.
  assign mid_byte = ((state_q == MON_DATA) && (cnt_q != 4'd0)) || (state_q == MON_ACK);

  // Receive FSM: conditions take priority over data sampling.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    first_d      = first_q;
    busy_d       = busy_q;
    start_d      = 1'b0;
    rstart_d     = 1'b0;
    stop_d       = 1'b0;
    ferr_d       = 1'b0;
    comp_d       = comp_q;
    comp_valid_d = 1'b0;
    if (start_cond) begin
      ferr_d   = mid_byte;
      start_d  = ~busy_q;
      rstart_d = busy_q;
      busy_d   = 1'b1;
      state_d  = MON_DATA;
      cnt_d    = 4'd0;
      first_d  = 1'b1;
    end else if (stop_cond) begin
      ferr_d  = mid_byte;
      stop_d  = 1'b1;
      busy_d  = 1'b0;
      state_d = MON_IDLE;
      cnt_d   = 4'd0;
    end else if (scl_rise) begin
      case (state_q)
        MON_IDLE: ;
        MON_DATA: begin
          shift_d = {shift_q[I2C_BYTE_BITS-2:0], sda_s};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST_BIT) state_d = MON_ACK;
        end
        MON_ACK: begin
          comp_d       = '{data: shift_q, ack: sda_s, first: first_q};
          comp_valid_d = 1'b1;
          first_d      = 1'b0;
          cnt_d        = 4'd0;
          state_d      = MON_DATA;
        end
        default: state_d = MON_IDLE;
      endcase
    end
  end

  // FSM, shifter, pulse and completed-byte registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_p        <= 1'b1;
      sda_p        <= 1'b1;
      state_q      <= MON_IDLE;
      cnt_q        <= 4'd0;
      shift_q      <= '0;
      first_q      <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      rstart_q     <= 1'b0;
      stop_q       <= 1'b0;
      ferr_q       <= 1'b0;
      comp_q       <= '0;
      comp_valid_q <= 1'b0;
    end else begin
      scl_p        <= scl_s;
      sda_p        <= sda_s;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      first_q      <= first_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      rstart_q     <= rstart_d;
      stop_q       <= stop_d;
      ferr_q       <= ferr_d;
      comp_q       <= comp_d;
      comp_valid_q <= comp_valid_d;
    end
  end

  // Holding register: accept-and-refill in one cycle keeps valid high; full drops the new byte.
  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    ovf_d        = 1'b0;
    if (hold_valid_q && byte_ready) hold_valid_d = 1'b0;
    if (comp_valid_q) begin
      if (!hold_valid_q || byte_ready) begin
        hold_d       = comp_q;
        hold_valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Holding register and overflow pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign byte_data    = hold_q.data;
  assign byte_ack     = hold_q.ack;
  assign byte_first   = hold_q.first;
  assign byte_valid   = hold_valid_q;
  assign start_pulse  = start_q;
  assign rstart_pulse = rstart_q;
  assign stop_pulse   = stop_q;
  assign bus_busy     = busy_q;
  assign overflow     = ovf_q;
  assign frame_err    = ferr_q;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench for i2c_bus_monitor: table-driven byte transactions plus directed
// sequences for reset, overflow, framing error and short SDA glitches.
module tb_i2c_bus_monitor;

  localparam int HP = 8;  // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_i = 1'b0;
  logic       sda_i = 1'b0;
  logic       byte_ready = 1'b0;
  logic [7:0] byte_data;
  logic       byte_ack, byte_first, byte_valid;
  logic       start_pulse, rstart_pulse, stop_pulse, bus_busy, overflow, frame_err;

  i2c_bus_monitor dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .byte_data   (byte_data),
    .byte_ack    (byte_ack),
    .byte_first  (byte_first),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .start_pulse (start_pulse),
    .rstart_pulse(rstart_pulse),
    .stop_pulse  (stop_pulse),
    .bus_busy    (bus_busy),
    .overflow    (overflow),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_start = 0, n_rstart = 0, n_stop = 0, n_ovf = 0, n_ferr = 0, n_valid = 0;
  logic [9:0] got_q[$];
  logic prev_cond = 1'b0;

  // Event counters, byte capture and condition-pulse shape checks.
  always @(negedge clk) begin
    if (reset_n) begin
      if (start_pulse) n_start++;
      if (rstart_pulse) n_rstart++;
      if (stop_pulse) n_stop++;
      if (overflow) n_ovf++;
      if (frame_err) n_ferr++;
      if (byte_valid) n_valid++;
      if (byte_valid && byte_ready) got_q.push_back({byte_data, byte_ack, byte_first});
      if (start_pulse || rstart_pulse || stop_pulse) begin
        total++;
        if ((int'(start_pulse) + int'(rstart_pulse) + int'(stop_pulse)) != 1 || prev_cond) begin
          bad++;
          $display("FAIL cond_pulse_shape: start=%0b rstart=%0b stop=%0b prev=%0b want one 1-clk pulse",
                   start_pulse, rstart_pulse, stop_pulse, prev_cond);
        end
      end
      prev_cond = start_pulse | rstart_pulse | stop_pulse;
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_t(input logic b);
    sda_i = b;
    clks(HP / 2);
    scl_i = 1'b1;
    clks(HP);
    scl_i = 1'b0;
    clks(HP / 2);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack);
    for (int i = 7; i >= 0; i--) bit_t(d[i]);
    bit_t(ack);
  endtask

  // Works both from idle (SCL/SDA high) and mid-transfer (SCL low).
  task automatic start_c();
    sda_i = 1'b1;
    clks(HP / 2);
    scl_i = 1'b1;
    clks(HP);
    sda_i = 1'b0;
    clks(HP);
    scl_i = 1'b0;
    clks(HP / 2);
  endtask

  task automatic stop_c();
    sda_i = 1'b0;
    clks(HP / 2);
    scl_i = 1'b1;
    clks(HP);
    sda_i = 1'b1;
    clks(HP);
  endtask

  task automatic wait_byte(output logic [9:0] b, output bit ok);
    ok = 1'b0;
    b  = '0;
    for (int i = 0; i < 100; i++) begin
      if (got_q.size() > 0) begin
        b  = got_q.pop_front();
        ok = 1'b1;
        break;
      end
      clks(1);
    end
  endtask

  typedef struct {
    bit         do_start;
    logic [7:0] data;
    logic       ack;
    bit         do_stop;
    logic       exp_first;
    int         exp_start;
    int         exp_rstart;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, p0, o0, f0, v0;
    logic [9:0] b;
    bit ok;

    vecs[0] = '{1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 1, 0};
    vecs[1] = '{1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[2] = '{1'b1, 8'h50, 1'b0, 1'b0, 1'b1, 1, 0};
    vecs[3] = '{1'b1, 8'h51, 1'b0, 1'b1, 1'b1, 0, 1};

    // Reset with both lines low, then release.
    clks(4);
    chk("reset_outputs",
        int'({byte_data, byte_ack, byte_first, byte_valid, start_pulse, rstart_pulse,
              stop_pulse, bus_busy, overflow, frame_err}), 0);
    reset_n = 1'b1;
    clks(6);
    chk("post_reset_no_start", n_start, 0);
    chk("post_reset_busy", int'(bus_busy), 0);
    chk("post_reset_valid", int'(byte_valid), 0);
    scl_i = 1'b1;
    sda_i = 1'b1;
    clks(6);
    chk("release_no_start", n_start, 0);
    chk("release_no_stop", n_stop, 0);

    // Table-driven transactions, consumer always ready.
    byte_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 = n_start;
      r0 = n_rstart;
      if (vecs[i].do_start) begin
        start_c();
        chk($sformatf("v%0d_busy_after_start", i), int'(bus_busy), 1);
      end
      send_byte(vecs[i].data, vecs[i].ack);
      wait_byte(b, ok);
      chk($sformatf("v%0d_byte_seen", i), int'(ok), 1);
      chk($sformatf("v%0d_data", i), int'(b[9:2]), int'(vecs[i].data));
      chk($sformatf("v%0d_ack", i), int'(b[1]), int'(vecs[i].ack));
      chk($sformatf("v%0d_first", i), int'(b[0]), int'(vecs[i].exp_first));
      chk($sformatf("v%0d_start_cnt", i), n_start - s0, vecs[i].exp_start);
      chk($sformatf("v%0d_rstart_cnt", i), n_rstart - r0, vecs[i].exp_rstart);
      chk($sformatf("v%0d_busy", i), int'(bus_busy), 1);
      if (vecs[i].do_stop) begin
        p0 = n_stop;
        stop_c();
        chk($sformatf("v%0d_stop_cnt", i), n_stop - p0, 1);
        chk($sformatf("v%0d_idle", i), int'(bus_busy), 0);
      end
    end

    // Consumer stalled: first byte held, later two dropped.
    byte_ready = 1'b0;
    got_q.delete();
    o0 = n_ovf;
    start_c();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    clks(6);
    chk("hold_valid", int'(byte_valid), 1);
    chk("hold_data", int'(byte_data), 'h11);
    chk("overflow_cnt", n_ovf - o0, 2);
    byte_ready = 1'b1;
    clks(3);
    chk("hold_xfer_cnt", got_q.size(), 1);
    if (got_q.size() > 0) chk("hold_xfer_data", int'(got_q[0][9:2]), 'h11);
    chk("hold_drained", int'(byte_valid), 0);
    stop_c();
    got_q.delete();

    // STOP after five data bits.
    f0 = n_ferr;
    p0 = n_stop;
    v0 = n_valid;
    start_c();
    bit_t(1'b1);
    bit_t(1'b0);
    bit_t(1'b1);
    bit_t(1'b1);
    bit_t(1'b0);
    stop_c();
    clks(6);
    chk("ferr_cnt", n_ferr - f0, 1);
    chk("ferr_stop_cnt", n_stop - p0, 1);
    chk("ferr_no_valid", n_valid - v0, 0);
    chk("ferr_idle", int'(bus_busy), 0);

    // Short SDA low pulses with SCL high.
    s0 = n_start;
    sda_i = 1'b0;
    clks(2);
    sda_i = 1'b1;
    clks(12);
`ifdef I2C_GLITCH_FILTER_EN
    chk("glitch2_start", n_start - s0, 0);
`else
    chk("glitch2_start", n_start - s0, 1);
`endif
    sda_i = 1'b0;
    clks(6);
    sda_i = 1'b1;
    clks(12);
`ifdef I2C_GLITCH_FILTER_EN
    chk("glitch6_start", n_start - s0, 1);
`else
    chk("glitch6_start", n_start - s0, 2);
`endif
    chk("glitch_idle", int'(bus_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
